// File: rtl/rng_addr_arbiter_if.sv
// Requester-side bus of rng_addr_arbiter: packed per-agent requests plus the shared response.
// The master modport is the agent side; the slave modport is the arbiter side.
interface rng_addr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_count;
  logic [NREQ*W-1:0] req_which;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [W-1:0]      rsp_address;
  logic              rsp_err;

  modport master (
    output req_valid, req_count, req_which,
    input  req_ready, rsp_valid, rsp_address, rsp_err
  );

  modport slave (
    input  req_valid, req_count, req_which,
    output req_ready, rsp_valid, rsp_address, rsp_err
  );
endinterface

// File: rtl/rng_addr_arbiter.sv
// Round-robin scheduler sharing one "which mod count" reducer among NREQ agents.
// Optional WAIT watchdog enabled by defining RNG_ARB_TIMEOUT_EN.
module rng_addr_arbiter #(
  parameter int NREQ        = 4,
  parameter int W           = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clock_i,
  input  logic              rst_i,
  rng_addr_arbiter_if.slave req_if,
  output logic              busy_o,
  output logic              u_nrst_o,
  output logic              u_start_o,
  output logic [W-1:0]      u_count_o,
  output logic [W-1:0]      u_which_o,
  input  logic [W-1:0]      u_address_i,
  input  logic              u_done_i
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, RESP} state_e;

  if (NREQ < 2 || NREQ > 16 || W < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("rng_addr_arbiter: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  u_count_q, u_count_d;
  logic [W-1:0]  u_which_q, u_which_d;
  logic [W-1:0]  rsp_address_q, rsp_address_d;
  logic          rsp_err_q, rsp_err_d;

`ifdef RNG_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > W) ? $clog2(TIMEOUT_CYC + 1) : W;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  logic [W-1:0] cnt_a [NREQ];
  logic [W-1:0] whc_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign cnt_a[g] = req_if.req_count[g*W +: W];
    assign whc_a[g] = req_if.req_which[g*W +: W];
  end

  // First valid agent after the last grant, wrapping; the last winner is checked last.
  logic          hit;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    hit  = 1'b0;
    win  = ptr_q;
    cand = ptr_q;
    for (int i = 1; i <= NREQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % NREQ);
      if (!hit && req_if.req_valid[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    u_count_d        = u_count_q;
    u_which_d        = u_which_q;
    rsp_address_d    = rsp_address_q;
    rsp_err_d        = rsp_err_q;
    req_if.req_ready = '0;
    req_if.rsp_valid = '0;
    u_start_o        = 1'b0;
`ifdef RNG_ARB_TIMEOUT_EN
    tmo_d            = tmo_q;
`endif
    if (!rst_i) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            req_if.req_ready = NREQ'(1) << win;
            ptr_d            = win;
            u_count_d        = cnt_a[win];
            u_which_d        = whc_a[win];
            // A zero divisor would keep the reducer spinning forever.
            if (cnt_a[win] == '0) begin
              rsp_err_d     = 1'b1;
              rsp_address_d = '0;
              state_d       = RESP;
            end else begin
              rsp_err_d = 1'b0;
              state_d   = CLEAR;
            end
          end
        end
        CLEAR: state_d = LAUNCH;
        LAUNCH: begin
          u_start_o = 1'b1;
          state_d   = WAIT;
`ifdef RNG_ARB_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end
        WAIT: begin
          if (u_done_i) begin
            rsp_address_d = u_address_i;
            state_d       = RESP;
          end
`ifdef RNG_ARB_TIMEOUT_EN
          else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            rsp_address_d = '0;
            rsp_err_d     = 1'b1;
            state_d       = RESP;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
        RESP: begin
          req_if.rsp_valid = NREQ'(1) << ptr_q;
          state_d          = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= PW'(NREQ - 1);
      u_count_q     <= '0;
      u_which_q     <= '0;
      rsp_address_q <= '0;
      rsp_err_q     <= 1'b0;
`ifdef RNG_ARB_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      u_count_q     <= u_count_d;
      u_which_q     <= u_which_d;
      rsp_address_q <= rsp_address_d;
      rsp_err_q     <= rsp_err_d;
`ifdef RNG_ARB_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  // The reducer only idles through reset, so it is held there during rst and pulsed in CLEAR.
  assign u_nrst_o           = !(rst_i || state_q == CLEAR);
  assign busy_o             = !rst_i && (state_q != IDLE);
  assign u_count_o          = u_count_q;
  assign u_which_o          = u_which_q;
  assign req_if.rsp_address = rsp_address_q;
  assign req_if.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_rng_addr_arbiter.sv
// Self-checking bench for rng_addr_arbiter with a behavioural reducer and round-robin reference model.
module tb_rng_addr_arbiter;
  localparam int NREQ        = 4;
  localparam int W           = 16;
  localparam int TIMEOUT_CYC = 1024;

  logic         clock = 1'b0;
  logic         rst   = 1'b1;
  logic         busy, u_nrst, u_start, u_done;
  logic [W-1:0] u_count, u_which, u_address;

  int n_checks = 0;
  int n_fail   = 0;

  rng_addr_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  rng_addr_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clock_i    (clock),
    .rst_i      (rst),
    .req_if     (bus),
    .busy_o     (busy),
    .u_nrst_o   (u_nrst),
    .u_start_o  (u_start),
    .u_count_o  (u_count),
    .u_which_o  (u_which),
    .u_address_i(u_address),
    .u_done_i   (u_done)
  );

  always #5 clock = ~clock;

  // Reducer: result which % count, done after which / count cycles, sticky until reset.
  logic [W-1:0] red_res;
  int unsigned  red_left;
  logic         red_run;
  always @(posedge clock) begin
    if (!u_nrst) begin
      u_done    <= 1'b0;
      u_address <= '0;
      red_run   <= 1'b0;
      red_left  <= 0;
      red_res   <= '0;
    end else if (u_start && !red_run) begin
      red_run <= 1'b1;
      if (u_count != 0) begin
        red_res  <= u_which % u_count;
        red_left <= u_which / u_count;
        if (u_which / u_count == 0) begin
          u_done    <= 1'b1;
          u_address <= u_which % u_count;
        end else begin
          u_address <= 16'hdead;
        end
      end
    end else if (red_run && !u_done && red_left != 0) begin
      red_left <= red_left - 1;
      if (red_left == 1) begin
        u_done    <= 1'b1;
        u_address <= red_res;
      end
    end
  end

  int nrst_pulses  = 0;
  int start_pulses = 0;
  int rsp_pulses   = 0;
  always @(negedge clock) begin
    if (!rst && !u_nrst) nrst_pulses++;
    if (u_start) start_pulses++;
    if (bus.rsp_valid != '0) rsp_pulses++;
  end

  logic [NREQ-1:0] st_valid;
  logic [W-1:0]    st_which [NREQ];
  logic [W-1:0]    st_count [NREQ];
  int              exp_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive();
    bus.req_valid = st_valid;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_count[i*W +: W] = st_count[i];
      bus.req_which[i*W +: W] = st_which[i];
    end
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] mask);
    for (int i = 1; i <= NREQ; i++) begin
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  task automatic rand_data(input int a);
    st_count[a] = 16'($urandom_range(1, 40));
    if ($urandom_range(0, 3) == 0) st_which[a] = 16'(st_count[a] * $urandom_range(0, 7));
    else                           st_which[a] = 16'($urandom_range(0, 300));
  endtask

  // Waits for req_ready; the expected winner comes from the round-robin rule.
  task automatic await_grant(input string tag, output int got, output int waited,
                             output logic [W-1:0] gw, output logic [W-1:0] gc);
    int  k;
    bit  seen;
    k      = rr_pick(exp_ptr, st_valid);
    seen   = 0;
    waited = 0;
    got    = -1;
    gw     = '0;
    gc     = '0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clock);
      seen   = (bus.req_ready != '0);
      waited = c;
    end
    check({tag, "_grant_seen"}, 32'(seen), 32'd1);
    if (seen && k >= 0) begin
      check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(1) << k);
      exp_ptr = k;
      got     = k;
      gw      = st_which[k];
      gc      = st_count[k];
    end
  endtask

  // Caller has taken k0 steps since the grant negedge.
  task automatic await_rsp(input string tag, input int a, input logic [W-1:0] which,
                           input logic [W-1:0] count, input int k0);
    int           lat, exp_lat;
    bit           seen;
    logic [W-1:0] exp_addr;
    logic         exp_err;
    if (count == 0) begin
      exp_lat = 1; exp_addr = '0; exp_err = 1'b1;
    end else begin
      exp_lat = 4 + int'(which / count); exp_addr = which % count; exp_err = 1'b0;
    end
`ifdef RNG_ARB_TIMEOUT_EN
    if (count != 0 && int'(which / count) >= TIMEOUT_CYC) begin
      exp_lat = 3 + TIMEOUT_CYC; exp_addr = '0; exp_err = 1'b1;
    end
`endif
    seen = 0;
    lat  = 0;
    for (int c = k0; c <= exp_lat + 16 && !seen; c++) begin
      @(negedge clock);
      if (bus.rsp_valid != '0) begin
        seen = 1;
        lat  = c;
      end
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_rsp_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1) << a);
      check({tag, "_rsp_address"}, 32'(bus.rsp_address), 32'(exp_addr));
      check({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
      check({tag, "_u_count_held"}, 32'(u_count), 32'(count));
      check({tag, "_u_which_held"}, 32'(u_which), 32'(which));
    end
  endtask

  task automatic single_job(input string tag, input int a, input logic [W-1:0] which,
                            input logic [W-1:0] count);
    int           got, waited, n0, s0;
    logic [W-1:0] gw, gc;
    step();
    st_valid    = '0;
    st_valid[a] = 1'b1;
    st_which[a] = which;
    st_count[a] = count;
    drive();
    n0 = nrst_pulses;
    s0 = start_pulses;
    await_grant(tag, got, waited, gw, gc);
    check({tag, "_grant_wait"}, 32'(waited), 32'd0);
    step();
    st_valid = '0;
    drive();
    if (got >= 0) await_rsp(tag, got, gw, gc, 1);
    step();
    check({tag, "_nrst_pulses"}, 32'(nrst_pulses - n0), (count == 0) ? 32'd0 : 32'd1);
    check({tag, "_start_pulses"}, 32'(start_pulses - s0), (count == 0) ? 32'd0 : 32'd1);
  endtask

  task automatic do_reset();
    step();
    rst      = 1'b1;
    st_valid = '0;
    drive();
    step();
    rst     = 1'b0;
    exp_ptr = NREQ - 1;
  endtask

  initial begin
    int           got, waited, p0;
    bit           quiet;
    logic [W-1:0] gw, gc;

    st_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      st_which[i] = '0;
      st_count[i] = '0;
    end
    drive();
    exp_ptr = NREQ - 1;

    // Reset state, with a request pending that must not be accepted.
    step();
    st_valid[0] = 1'b1; st_which[0] = 16'd5; st_count[0] = 16'd3;
    drive();
    @(negedge clock);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_address", 32'(bus.rsp_address), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_u_nrst", 32'(u_nrst), 32'd0);
    check("reset_u_start", 32'(u_start), 32'd0);
    check("reset_u_count", 32'(u_count), 32'd0);
    check("reset_u_which", 32'(u_which), 32'd0);
    step();
    st_valid = '0;
    drive();
    rst = 1'b0;
    @(negedge clock);
    check("post_reset_u_nrst", 32'(u_nrst), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);

    single_job("a0_10_mod_3", 0, 16'd10, 16'd3);
    single_job("a2_6_mod_3", 2, 16'd6, 16'd3);
    single_job("a2_2_mod_5", 2, 16'd2, 16'd5);
    single_job("a1_which0", 1, 16'd0, 16'd9);
    single_job("a1_count0", 1, 16'd7, 16'd0);
    single_job("a3_count1", 3, 16'd13, 16'd1);

    // All agents valid continuously after reset: grants go 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      st_valid[i] = 1'b1;
      rand_data(i);
    end
    drive();
    for (int j = 0; j < 2 * NREQ; j++) begin
      await_grant($sformatf("rr%0d", j), got, waited, gw, gc);
      check($sformatf("rr%0d_grant_wait", j), 32'(waited), 32'd0);
      step();
      if (got >= 0) rand_data(got);
      drive();
      if (got >= 0) await_rsp($sformatf("rr%0d", j), got, gw, gc, 1);
    end
    step();
    st_valid = '0;
    drive();

    // Random request masks; losers drop their request after the grant.
    for (int j = 0; j < 10; j++) begin
      step();
      st_valid = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) if (st_valid[i]) rand_data(i);
      drive();
      await_grant($sformatf("mask%0d", j), got, waited, gw, gc);
      step();
      st_valid = '0;
      drive();
      if (got >= 0) await_rsp($sformatf("mask%0d", j), got, gw, gc, 1);
    end

    // Agent 3 requests briefly while the arbiter is busy, then drops: it is skipped.
    step();
    st_valid = '0; st_valid[0] = 1'b1; st_which[0] = 16'd200; st_count[0] = 16'd2;
    drive();
    await_grant("drop", got, waited, gw, gc);
    step();
    st_valid = '0; st_valid[3] = 1'b1; st_which[3] = 16'd9; st_count[3] = 16'd4;
    drive();
    step();
    step();
    step();
    st_valid = '0;
    drive();
    if (got >= 0) await_rsp("drop", got, gw, gc, 4);
    quiet = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (bus.req_ready != '0 || busy) quiet = 0;
    end
    check("drop_no_grant", 32'(quiet), 32'd1);

    // Reset in the middle of WAIT aborts the job without a response.
    step();
    st_valid = '0; st_valid[0] = 1'b1; st_which[0] = 16'd300; st_count[0] = 16'd1;
    drive();
    await_grant("midwait", got, waited, gw, gc);
    step();
    st_valid = '0;
    drive();
    for (int c = 0; c < 5; c++) step();
    p0  = rsp_pulses;
    rst = 1'b1;
    @(negedge clock);
    check("midwait_rst_u_nrst", 32'(u_nrst), 32'd0);
    check("midwait_rst_busy", 32'(busy), 32'd0);
    check("midwait_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    step();
    rst     = 1'b0;
    exp_ptr = NREQ - 1;
    @(negedge clock);
    check("midwait_after_busy", 32'(busy), 32'd0);
    check("midwait_after_u_count", 32'(u_count), 32'd0);
    check("midwait_after_u_which", 32'(u_which), 32'd0);
    check("midwait_after_rsp_address", 32'(bus.rsp_address), 32'd0);
    check("midwait_after_u_start", 32'(u_start), 32'd0);
    for (int c = 0; c < 400; c++) step();
    check("midwait_no_rsp", 32'(rsp_pulses - p0), 32'd0);
    single_job("after_abort", 2, 16'd2, 16'd5);

    // Maximum draw against count 1: long reducer run, or watchdog when enabled.
    single_job("max_which", 1, 16'hffff, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rng_addr_arbiter.md
Name: rng_addr_arbiter

Overview:
- Round-robin scheduler sharing one random-address modulo reducer among NREQ search agents.
- Each agent submits a random draw (`which`) and its better-neighbour count (`count`).
- The arbiter runs one job at a time on the shared reducer and returns `which mod count` to the winning agent.
- The reducer only returns to idle through its active-low reset, so the arbiter pulses that reset before every job.

Parameters:
- NREQ, 4, number of requesters (2..16).
- W, 16, width of count, which and address.
- TIMEOUT_CYC, 1024, max WAIT cycles per job; used only when RNG_ARB_TIMEOUT_EN is defined.

Ports:
- clock  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NREQ  per-agent request; hold high with stable data until req_ready.
- req_count  in  NREQ*W  packed; agent i at [i*W +: W].
- req_which  in  NREQ*W  packed; agent i at [i*W +: W].
- req_ready  out  NREQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the granted agent.
- rsp_address  out  W  result; valid while any rsp_valid bit is high, held afterwards.
- rsp_err  out  1  qualifies rsp_valid: job aborted, rsp_address = 0.
- busy  out  1  high in every state except IDLE.
- u_nrst  out  1  active-low reset to the reducer.
- u_start  out  1  reducer start.
- u_count  out  W  reducer betterNeighborCount.
- u_which  out  W  reducer which.
- u_address  in  W  reducer result.
- u_done  in  1  reducer done; stays high until the reducer is reset.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, grant pointer=NREQ-1.
  - req_ready, rsp_valid, rsp_address, rsp_err, u_start, u_count, u_which are all 0; busy=0.
  - u_nrst = !(rst || state==CLEAR), combinational, so the reducer is held in reset while rst is high.
- States: IDLE, CLEAR, LAUNCH, WAIT, RESP.
- IDLE:
  - Search req_valid starting at pointer+1, wrapping modulo NREQ.
  - On the first set bit k: pulse req_ready[k], latch count/which into u_count/u_which, set pointer=k.
  - If the latched count==0, go to RESP with error set (the reducer would never terminate). Otherwise go to CLEAR.
  - No valid bits: stay in IDLE.
- CLEAR: u_nrst=0 for exactly one cycle, then go to LAUNCH.
- LAUNCH: u_start=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - u_start=0.
  - When u_done=1, capture u_address into rsp_address and go to RESP.
  - u_done sampled in the same cycle as state entry counts.
- RESP:
  - rsp_valid[pointer]=1 for one cycle; rsp_err as determined; go to IDLE.
  - The next grant can occur in the IDLE cycle that follows.
- Arithmetic: the result equals which mod count, for which=0 and for which equal to any multiple of count (result 0).
- Grant latency: req_ready pulses in the first IDLE cycle in which the agent wins.
- Response latency: 4 + (reducer cycles) after req_ready; a zero-count job responds in 1 cycle.
- A requester that drops req_valid before its grant is skipped; no grant, no response.
- u_count and u_which stay stable from grant until the next grant.
- rst during any state: abort immediately with no rsp_valid; the granted agent must re-request.
- Only one job is in flight; req_ready is never asserted outside IDLE.

Optional Feature:
- Macro: RNG_ARB_TIMEOUT_EN.
- Defined: a W-bit-or-wider counter clears on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT_CYC without u_done, go to RESP with rsp_err=1 and rsp_address=0. The reducer is cleared by the next job's CLEAR state.
- Undefined: WAIT waits indefinitely and rsp_err is asserted only for count==0.

Test Plan:
- Agent 0: which=10, count=3 → req_ready[0] the next cycle; rsp_valid[0] with rsp_address=1, rsp_err=0.
- Agent 2: which=6, count=3 → rsp_address=0, rsp_err=0 (equality case). Then which=2, count=5 → rsp_address=2.
- All four agents valid continuously after reset → grant order 0,1,2,3,0. Each rsp_valid matches its own which mod count.
- Agent 1: count=0, which=7 → req_ready[1], then rsp_valid[1] on the next cycle with rsp_err=1, rsp_address=0; u_nrst and u_start never pulse.
- rst asserted for one cycle mid-WAIT → all outputs 0, state IDLE, no rsp_valid. A new request then completes normally.
- which=65535, count=1:
  - With RNG_ARB_TIMEOUT_EN: rsp_err=1, address 0, about 1024 cycles after LAUNCH.
  - Without the macro: rsp_address=0, rsp_err=0 after roughly 65535 reducer cycles.
